regfile_write_arbiter: RTL

Shares the single write port of the 32x32 register file between two writeback requesters: A (ALU result) and B (memory load). Each requester has a small FIFO with a valid/ready handshake, and a round-robin arbiter drains the FIFOs one write per cycle. The block drives the register file's ADDR_W, DATA_W, WRITE and READ inputs. It also reports pending-write status for the two read addresses so decode can stall on a RAW hazard.

---
 rtl/regfile_write_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester FIFO'd round-robin arbiter for the register file write port
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  A_VALID,
    output logic                  A_READY,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [DATA_WIDTH-1:0] A_DATA,
    input  logic                  B_VALID,
    output logic                  B_READY,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] B_DATA,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
    output logic [DATA_WIDTH-1:0] RF_DATA_W,
    output logic                  RF_WRITE,
    output logic                  RF_READ,
    input  logic [ADDR_WIDTH-1:0] CHK_ADDR1,
    input  logic [ADDR_WIDTH-1:0] CHK_ADDR2,
    output logic                  CHK_PEND1,
    output logic                  CHK_PEND2,
    output logic                  IDLE
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    // Index 0 is requester A, index 1 is requester B.
    logic [ADDR_WIDTH-1:0] addr_mem_q [2][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [2][FIFO_DEPTH];
    logic [PW-1:0]         wptr_q [2];
    logic [PW-1:0]         wptr_d [2];
    logic [PW-1:0]         rptr_q [2];
    logic [PW-1:0]         rptr_d [2];
    logic [CW-1:0]         count_q [2];
    logic [CW-1:0]         count_d [2];

    logic                  pri_q, pri_d;
    logic                  rf_write_q, rf_write_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;

    logic [1:0]            in_valid, ready, push, grant, nonempty;
    logic [ADDR_WIDTH-1:0] in_addr [2];
    logic [DATA_WIDTH-1:0] in_data [2];
    logic [ADDR_WIDTH-1:0] head_addr [2];
    logic [DATA_WIDTH-1:0] head_data [2];
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic [PW-1:0]         slot_off;
    logic                  hit1, hit2;

    // Handshake, FIFO heads and pointer/count next-state; ready only reflects
    // occupancy at the start of the cycle, so a same-cycle pop never frees a slot.
    always_comb begin
        in_valid     = {B_VALID, A_VALID};
        in_addr[0]   = A_ADDR;
        in_addr[1]   = B_ADDR;
        in_data[0]   = A_DATA;
        in_data[1]   = B_DATA;
        for (int r = 0; r < 2; r++) begin
            nonempty[r]  = (count_q[r] != '0);
            ready[r]     = (count_q[r] != CW'(FIFO_DEPTH)) && !RST;
            push[r]      = in_valid[r] && ready[r];
            head_addr[r] = addr_mem_q[r][rptr_q[r]];
            head_data[r] = data_mem_q[r][rptr_q[r]];
            wptr_d[r]    = push[r]  ? wptr_q[r] + PW'(1) : wptr_q[r];
            rptr_d[r]    = grant[r] ? rptr_q[r] + PW'(1) : rptr_q[r];
            count_d[r]   = count_q[r] + CW'(push[r]) - CW'(grant[r]);
        end
        A_READY = ready[0];
        B_READY = ready[1];
    end

    // Round-robin grant and the registered write-port image; an address-0 head
    // is popped and still flips priority, but never raises the write strobe.
    always_comb begin
        grant[0]   = nonempty[0] && (!nonempty[1] || !pri_q);
        grant[1]   = nonempty[1] && (!nonempty[0] ||  pri_q);
        gnt_addr   = grant[1] ? head_addr[1] : head_addr[0];
        gnt_data   = grant[1] ? head_data[1] : head_data[0];
        pri_d      = pri_q;
        if (grant[0]) begin
            pri_d = 1'b1;
        end else if (grant[1]) begin
            pri_d = 1'b0;
        end
        rf_write_d = (|grant) && (gnt_addr != '0);
        rf_addr_d  = rf_write_d ? gnt_addr : rf_addr_q;
        rf_data_d  = rf_write_d ? gnt_data : rf_data_q;
    end

    // Control state: pointers, counts, priority and the write-port registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < 2; r++) begin
                wptr_q[r]  <= '0;
                rptr_q[r]  <= '0;
                count_q[r] <= '0;
            end
            pri_q      <= 1'b0;
            rf_write_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                wptr_q[r]  <= wptr_d[r];
                rptr_q[r]  <= rptr_d[r];
                count_q[r] <= count_d[r];
            end
            pri_q      <= pri_d;
            rf_write_q <= rf_write_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
        end
    end

    // FIFO storage; written only on an accepted handshake, which reset blocks.
    always_ff @(posedge CLK) begin
        for (int r = 0; r < 2; r++) begin
            if (push[r]) begin
                addr_mem_q[r][wptr_q[r]] <= in_addr[r];
                data_mem_q[r][wptr_q[r]] <= in_data[r];
            end
        end
    end

    // Hazard lookup: a slot is live when its distance from the read pointer
    // is below the count; the in-flight write also counts as pending.
    always_comb begin
        hit1     = 1'b0;
        hit2     = 1'b0;
        slot_off = '0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                slot_off = PW'(i) - rptr_q[r];
                if ({1'b0, slot_off} < count_q[r]) begin
                    if (addr_mem_q[r][i] == CHK_ADDR1) hit1 = 1'b1;
                    if (addr_mem_q[r][i] == CHK_ADDR2) hit2 = 1'b1;
                end
            end
        end
        if (rf_write_q && rf_addr_q == CHK_ADDR1) hit1 = 1'b1;
        if (rf_write_q && rf_addr_q == CHK_ADDR2) hit2 = 1'b1;
        CHK_PEND1 = hit1 && (CHK_ADDR1 != '0);
        CHK_PEND2 = hit2 && (CHK_ADDR2 != '0);
    end

    assign RF_ADDR_W = rf_addr_q;
    assign RF_DATA_W = rf_data_q;
    assign RF_WRITE  = rf_write_q;
    assign RF_READ   = ~rf_write_q;
    assign IDLE      = ~nonempty[0] & ~nonempty[1] & ~rf_write_q;

endmodule
